trace_arbiter: RTL and testbench
================================

# trace_arbiter

- Round-robin arbiter that shares one bitwise-AND compute-and-trace datapath among `NUM_REQ` requesters.
- Each requester offers an operand pair (a, b) over valid/ready. The block accepts one winner per cycle, computes `a & b`, and presents the registered result on a single valid/ready trace output.
- Sits between several producer blocks and the single debug/trace sink, and serialises their records without starvation.

## Interface

Parameters:

- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 2: operand and result width in bits.
- `CNT_W`, default 16: width of the grant statistics counter.

Ports:

- `clock` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low reset.
- `req_valid` input `NUM_REQ`: per-requester record valid.
- `req_a` input `NUM_REQ*WIDTH`: operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` input `NUM_REQ*WIDTH`: operand b, same packing as `req_a`.
- `req_ready` output `NUM_REQ`: one-hot or zero; accept strobe for the granted requester.
- `out_valid` output 1: trace record available.
- `out_ready` input 1: sink accepts the record.
- `out_src` output `$clog2(NUM_REQ)`: index of the originating requester.
- `out_a` output `WIDTH`: captured operand a.
- `out_b` output `WIDTH`: captured operand b.
- `out_res` output `WIDTH`: `out_a & out_b`.
- `grant_count` output `CNT_W`: total records accepted; saturates at all-ones.

## Operation

- FSM has two states:
  - EMPTY: output register holds nothing.
  - FULL: output register holds a record.
- Output slot is free when state is EMPTY, or when state is FULL and `out_ready` is 1.
- Round-robin pointer `ptr` (`$clog2(NUM_REQ)` bits):
  - Search order is ptr, ptr+1, …, wrapping modulo `NUM_REQ`.
  - The first requester with `req_valid` set is the winner.
- `req_ready[winner]` = 1 only when the slot is free and some `req_valid` is set. All other bits are 0.
  - `req_ready` is combinational from `req_valid`, `out_ready` and state.
- Accept (a valid/ready handshake on the winner) does all of the following at the next edge:
  - Capture a, b and the result into the output register, and capture the winner index into `out_src`.
  - Update `ptr` to (winner+1) mod `NUM_REQ`, including the wrap from `NUM_REQ-1` to 0.
  - Increment `grant_count` unless it is already all-ones.
- Transitions:
  - EMPTY with an accept → FULL.
  - FULL with `out_ready` and an accept → FULL, loaded with the new record (back-to-back transfer).
  - FULL with `out_ready` and no `req_valid` → EMPTY.
  - FULL with `out_ready` = 0 → FULL. `out_*` stay stable and `req_ready` is all 0.
- `ptr` is unchanged on any cycle without an accept.
- `NUM_REQ` must be a power of two, so that `ptr` wraps without an extra compare.

## Timing

- Latency: accept on cycle N gives `out_valid` = 1 with the record on cycle N+1.
- Throughput: one record per cycle while the sink holds `out_ready` = 1.
- A requester may drop `req_valid` without penalty if it has not been granted.
- Once `out_valid` is 1, `out_valid`, `out_src`, `out_a`, `out_b` and `out_res` hold until the `out_valid` && `out_ready` handshake.
- Reset (`reset` = 0 sampled at a rising edge):
  - State → EMPTY, `ptr` = 0, `out_valid` = 0.
  - `out_src`, `out_a`, `out_b` and `out_res` = 0; `grant_count` = 0.
  - `req_ready` = 0 while `reset` is 0.
- Reset mid-operation discards any held record. No handshake completes on the reset cycle.
- Simultaneous requests from all requesters are each granted exactly once in every `NUM_REQ` consecutive accepts.

## Structure

- Shared package `trace_arb_pkg`:
  - FSM state enum `{ST_EMPTY, ST_FULL}`.
  - Default parameter constants.
  - Record struct `{src, a, b, res}`.
- Sub-module `rr_pick` (purely combinational):
  - Inputs: `req` vector and `ptr`.
  - Outputs: `any`, a one-hot `gnt` vector and the binary `idx`.
  - Implemented as a double-width masked priority encode.

## Test plan

- Single requester, 2 valid records, `out_ready` = 1: req 2 sends a=3,b=1 → `out_src`=2, `out_res`=1 one cycle later; next record a=2,b=3 → `out_res`=2; `grant_count`=2.
- All 4 requesters valid, `out_ready` held 1, after reset: grant order is 0,1,2,3,0.
- Backpressure: record loaded, `out_ready` = 0 for 3 cycles → `req_ready` is 0 and `out_*` are unchanged; `out_ready` = 1 → back-to-back reload on that same cycle.
- Wrap: only req 3 valid → `ptr` becomes 0; then reqs 0 and 3 both valid → req 0 granted first.
- Reset mid-FULL: `reset` = 0 while `out_valid` = 1 → next cycle `out_valid` = 0, `grant_count` = 0, `ptr` = 0.
- Saturation: force `CNT_W` = 4 and send 20 records → `grant_count` stays at 15.

Source files
------------

// File: rtl/trace_arb_pkg.sv
// trace_arb_pkg: shared state encoding, default sizes and record layout
// for the trace arbiter and its round-robin picker.
package trace_arb_pkg;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 2;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   // Record layout at the default sizes; the top re-declares it at its own widths.
   typedef struct packed {
      logic [$clog2(DEF_NUM_REQ)-1:0] src;
      logic [DEF_WIDTH-1:0]           a;
      logic [DEF_WIDTH-1:0]           b;
      logic [DEF_WIDTH-1:0]           res;
   } rec_t;
endpackage

// File: rtl/trace_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after
// ptr wins, found by a priority encode over the request vector seen twice.
module rr_pick
   import trace_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          any,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx
);
   logic [2*N-1:0] dbl;

   always_comb begin
      dbl = {req, req} & {{N{1'b1}}, ~((N'(1) << ptr) - N'(1))};
      idx = '0;
      // Scan downward so the lowest masked position wins; upper copy covers the wrap.
      for (int i = 2*N-1; i >= 0; i--) if (dbl[i]) idx = PW'(i);
      any = |req;
      gnt = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/trace_arbiter.sv
// trace_arbiter: round-robin share of one AND-and-trace datapath among
// NUM_REQ requesters, with a single registered valid/ready output slot.
module trace_arbiter
   import trace_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CNT_W   = DEF_CNT_W,
   localparam int PW     = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PW-1:0]            out_src,
   output logic [WIDTH-1:0]         out_a,
   output logic [WIDTH-1:0]         out_b,
   output logic [WIDTH-1:0]         out_res,
   output logic [CNT_W-1:0]         grant_count
);
   typedef struct packed {
      logic [PW-1:0]    src;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
   } trace_rec_t;

   state_t             state_q;
   trace_rec_t         rec_q, rec_d;
   logic [PW-1:0]      ptr_q, idx;
   logic [CNT_W-1:0]   cnt_q;
   logic [NUM_REQ-1:0] gnt;
   logic               any, accept;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req(req_valid),
      .ptr(ptr_q),
      .any(any),
      .gnt(gnt),
      .idx(idx)
   );

   always_comb begin
      accept    = reset && any && (state_q == ST_EMPTY || out_ready);
      req_ready = accept ? gnt : '0;
      rec_d.src = idx;
      rec_d.a   = req_a[int'(idx)*WIDTH +: WIDTH];
      rec_d.b   = req_b[int'(idx)*WIDTH +: WIDTH];
      rec_d.res = rec_d.a & rec_d.b;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         rec_q   <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         state_q <= ST_FULL;
         ptr_q   <= idx + PW'(1);
         rec_q   <= rec_d;
         cnt_q   <= cnt_q + CNT_W'(~&cnt_q);
      end else if (out_ready) begin
         state_q <= ST_EMPTY;
      end
   end

   assign out_valid   = (state_q == ST_FULL);
   assign out_src     = rec_q.src;
   assign out_a       = rec_q.a;
   assign out_b       = rec_q.b;
   assign out_res     = rec_q.res;
   assign grant_count = cnt_q;
endmodule

// File: tb/tb_trace_arbiter.sv
// tb_trace_arbiter: directed and random stimulus against a queue-free
// behavioural model of the round-robin trace arbiter (4 requesters, 4-bit counter).
module tb_trace_arbiter;
   localparam int N = 4;
   localparam int W = 2;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [1:0]     out_src;
   logic [W-1:0]   out_a, out_b, out_res;
   logic [CW-1:0]  grant_count;

   int checks = 0;
   int errors = 0;
   int m_ptr, m_src, m_a, m_b, m_res, m_cnt;
   bit m_full;

   trace_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_a(req_a),
      .req_b(req_b),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_src(out_src),
      .out_a(out_a),
      .out_b(out_b),
      .out_res(out_res),
      .grant_count(grant_count)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs();
      chk("out_valid", 32'(out_valid), 32'(m_full));
      chk("out_src", 32'(out_src), m_src);
      chk("out_a", 32'(out_a), m_a);
      chk("out_b", 32'(out_b), m_b);
      chk("out_res", 32'(out_res), m_res);
      chk("grant_count", 32'(grant_count), m_cnt);
   endtask

   task automatic model_reset();
      m_ptr = 0; m_full = 0; m_src = 0; m_a = 0; m_b = 0; m_res = 0; m_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      req_valid = '1;
      out_ready = 1'b1;
      #1;
      chk("ready_in_reset", 32'(req_ready), 0);
      @(posedge clock);
      #1;
      model_reset();
      check_outs();
      reset = 1'b1;
      req_valid = '0;
   endtask

   // One cycle: drive, check the accept strobe, advance the model, check the registered record.
   task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] av, input logic [N*W-1:0] bv, input logic ordy);
      int win;
      @(negedge clock);
      req_valid = v;
      req_a = av;
      req_b = bv;
      out_ready = ordy;
      #1;
      win = -1;
      if (!m_full || ordy)
         for (int k = 0; k < N; k++) if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      chk("req_ready", 32'(req_ready), win >= 0 ? (1 << win) : 0);
      if (win >= 0) begin
         m_full = 1;
         m_src = win;
         m_a = int'(av[win*W +: W]);
         m_b = int'(bv[win*W +: W]);
         m_res = m_a & m_b;
         m_ptr = (win + 1) % N;
         m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
      end else if (ordy) begin
         m_full = 0;
      end
      @(posedge clock);
      #1;
      check_outs();
   endtask

   initial begin
      model_reset();
      do_reset();
      // Single requester 2: (3,1) then (2,3).
      step(4'b0100, 8'b00_11_00_00, 8'b00_01_00_00, 1'b1);
      chk("tp1_src", 32'(out_src), 2);
      chk("tp1_res", 32'(out_res), 1);
      step(4'b0100, 8'b00_10_00_00, 8'b00_11_00_00, 1'b1);
      chk("tp1_res2", 32'(out_res), 2);
      chk("tp1_cnt", 32'(grant_count), 2);
      // All requesters, fair order from ptr 0.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'hF, 8'($urandom), 8'($urandom), 1'b1);
         chk("rr_order", 32'(out_src), i % N);
      end
      // Backpressure then back-to-back reload.
      for (int i = 0; i < 3; i++) step(4'hF, 8'($urandom), 8'($urandom), 1'b0);
      step(4'hF, 8'hE4, 8'hFF, 1'b1);
      chk("bp_reload_src", 32'(out_src), 1);
      // Wrap from requester 3 back to 0.
      do_reset();
      step(4'b1000, 8'($urandom), 8'($urandom), 1'b1);
      chk("wrap_src3", 32'(out_src), 3);
      step(4'b1001, 8'($urandom), 8'($urandom), 1'b1);
      chk("wrap_src0", 32'(out_src), 0);
      // Reset while a record is held.
      chk("full_before_reset", 32'(out_valid), 1);
      do_reset();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_cnt", 32'(grant_count), 0);
      step(4'hF, 8'($urandom), 8'($urandom), 1'b1);
      chk("rst_ptr0", 32'(out_src), 0);
      // Counter saturation.
      do_reset();
      for (int i = 0; i < 20; i++) step(4'hF, 8'($urandom), 8'($urandom), 1'b1);
      chk("sat_cnt", 32'(grant_count), CMAX);
      // Random traffic with occasional reset.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         step(4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
